keypad_seq_player: RTL

//  Keypad stimulus driver for the combination-lock FSM: plays a latched code as timed press pulses on A/B/C.

---
 rtl/keypad_pkg.sv | 49 ++++
 rtl/keypad_phase_timer.sv | 41 ++++
 rtl/keypad_seq_player.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad types: symbol encoding, player states and small helpers
// used by the sequence player and by the lock bench.
package keypad_pkg;

    typedef enum logic [1:0] {
        SYM_A     = 2'b00,
        SYM_B     = 2'b01,
        SYM_C     = 2'b10,
        SYM_PAUSE = 2'b11
    } sym_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS  = 3'd1,
        ST_GAP    = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } player_state_t;

    // One-hot button vector {C,B,A}; a pause drives nothing.
    function automatic logic [2:0] sym_to_btn(input sym_t s);
        logic [2:0] btn;
        case (s)
            SYM_A:   btn = 3'b001;
            SYM_B:   btn = 3'b010;
            SYM_C:   btn = 3'b100;
            default: btn = 3'b000;
        endcase
        return btn;
    endfunction

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        logic [3:0] res;
        if (len > max_len) begin
            res = max_len;
        end else begin
            res = len;
        end
        return res;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/keypad_phase_timer.sv
// Down-counter shared by the PRESS, GAP and CHECK phases: load a value,
// count to zero and hold there.
module keypad_phase_timer
    import keypad_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/keypad_seq_player.sv
// Plays a latched keypad code as press/release pulses on A/B/C, then waits
// for the lock LED and reports the outcome with a one-cycle DONE.
module keypad_seq_player
    import keypad_pkg::*;
#(
    parameter int MAX_LEN      = 8,
    parameter int PRESS_CYCLES = 2,
    parameter int GAP_CYCLES   = 3,
    parameter int TIMEOUT      = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [2*MAX_LEN-1:0]   CODE,
    input  logic [3:0]             LEN,
    input  logic                   LED_IN,
    output logic                   A_OUT,
    output logic                   B_OUT,
    output logic                   C_OUT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   PASS
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(max3(PRESS_CYCLES, GAP_CYCLES, TIMEOUT) + 1);
    localparam logic [TW-1:0] PRESS_LOAD = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] CHECK_LOAD = TW'(TIMEOUT - 1);

    player_state_t        state_q, state_d;
    logic [2*MAX_LEN-1:0] code_q, code_d;
    logic [LW-1:0]        len_q, len_d;
    logic [LW-1:0]        idx_q, idx_d;
    logic [2:0]           btn_q, btn_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 tmr_load_s;
    logic [TW-1:0]        tmr_val_s;
    logic                 tmr_zero_s;
    logic [3:0]           len_clamped_s;

    assign len_clamped_s = clamp_len(LEN, 4'(MAX_LEN));

    keypad_phase_timer #(.W(TW)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Sequencing: next state, next outputs and timer reloads. The current
    // symbol is always code_q[1:0]; the register shifts as each press ends.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        len_d      = len_q;
        idx_d      = idx_q;
        btn_d      = btn_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        case (state_q)
            ST_IDLE: begin
                btn_d  = 3'b000;
                busy_d = 1'b0;
                if (START) begin
                    code_d = CODE;
                    len_d  = LW'(len_clamped_s);
                    idx_d  = '0;
                    pass_d = 1'b0;
                    busy_d = 1'b1;
                    if (len_clamped_s == 4'd0) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_PRESS;
                        btn_d      = sym_to_btn(sym_t'(CODE[1:0]));
                        tmr_load_s = 1'b1;
                        tmr_val_s  = PRESS_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS: begin
                if (tmr_zero_s) begin
                    state_d    = ST_GAP;
                    btn_d      = 3'b000;
                    code_d     = {2'b00, code_q[2*MAX_LEN-1:2]};
                    tmr_load_s = 1'b1;
                    tmr_val_s  = GAP_LOAD;
                end else begin
                    state_d = ST_PRESS;
                end
            end
            ST_GAP: begin
                btn_d = 3'b000;
                if (tmr_zero_s) begin
                    idx_d      = idx_q + LW'(1);
                    tmr_load_s = 1'b1;
                    if ((idx_q + LW'(1)) == len_q) begin
                        state_d   = ST_CHECK;
                        tmr_val_s = CHECK_LOAD;
                    end else begin
                        state_d   = ST_PRESS;
                        btn_d     = sym_to_btn(sym_t'(code_q[1:0]));
                        tmr_val_s = PRESS_LOAD;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_CHECK: begin
                if (LED_IN) begin
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else if (tmr_zero_s) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                btn_d   = 3'b000;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            btn_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            btn_q   <= btn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign A_OUT = btn_q[0];
    assign B_OUT = btn_q[1];
    assign C_OUT = btn_q[2];
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign PASS  = pass_q;

endmodule
